// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC unit with PC register, hardware return stack and halt flag
module pc_sequencer #(
    parameter int ADDR_W = 16,
    parameter int STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pc_write,
    input  logic [1:0]                         instr_type,
    input  logic [4:0]                         opcode,
    input  logic                               zero_signal,
    input  logic                               stop_bit,
    input  logic [ADDR_W-1:0]                  imm_offset,
    input  logic [ADDR_W-1:0]                  jump_target,
    output logic [ADDR_W-1:0]                  pc,
    output logic [1:0]                         pc_src,
    output logic                               halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_ovf,
    output logic                               stack_udf
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [1:0] TYPE_I = 2'b01;
    localparam logic [1:0] TYPE_J = 2'b10;

    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_BNE  = 5'b01011;
    localparam logic [4:0] OP_JMP  = 5'b11010;
    localparam logic [4:0] OP_CALL = 5'b11011;
    localparam logic [4:0] OP_RET  = 5'b11100;

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JMP = 2'b10;
    localparam logic [1:0] SRC_POP = 2'b11;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic              stack_empty;
    logic              stack_full;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_br;
    logic [ADDR_W-1:0] stack_top;
    logic [ADDR_W-1:0] next_pc;
    logic              do_push;
    logic              do_pop;
    logic              do_halt;
    logic              set_udf;
    logic              commit;

    assign stack_empty = (stack_count == '0);
    assign stack_full  = (stack_count == CNT_W'(STACK_DEPTH));
    assign top_idx     = IDX_W'(stack_count - CNT_W'(1));
    assign push_idx    = IDX_W'(stack_count);
    assign pc_inc      = pc + ADDR_W'(1);
    assign pc_br       = pc + imm_offset;
    assign stack_top   = stack_mem[top_idx];
    assign commit      = pc_write && !halted;

    // stop_bit overrides the opcode entirely, so a CALL carrying it never pushes
    always_comb begin
        pc_src  = SRC_SEQ;
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_halt = 1'b0;
        set_udf = 1'b0;
        if (stop_bit) begin
            if (!stack_empty) begin
                pc_src = SRC_POP;
                do_pop = 1'b1;
            end else begin
                do_halt = 1'b1;
            end
        end else if (instr_type == TYPE_I) begin
            if ((opcode == OP_BEQ && zero_signal) || (opcode == OP_BNE && !zero_signal)) begin
                pc_src = SRC_BR;
            end
        end else if (instr_type == TYPE_J) begin
            case (opcode)
                OP_JMP: pc_src = SRC_JMP;
                OP_CALL: begin
                    pc_src  = SRC_JMP;
                    do_push = 1'b1;
                end
                OP_RET: begin
                    if (!stack_empty) begin
                        pc_src = SRC_POP;
                        do_pop = 1'b1;
                    end else begin
                        do_halt = 1'b1;
                        set_udf = 1'b1;
                    end
                end
                default: pc_src = SRC_SEQ;
            endcase
        end
    end

    always_comb begin
        next_pc = pc_inc;
        case (pc_src)
            SRC_SEQ: next_pc = pc_inc;
            SRC_BR:  next_pc = pc_br;
            SRC_JMP: next_pc = jump_target;
            SRC_POP: next_pc = stack_top;
            default: next_pc = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            stack_count <= '0;
            halted      <= 1'b0;
            stack_ovf   <= 1'b0;
            stack_udf   <= 1'b0;
        end else if (commit) begin
            if (do_halt) begin
                halted <= 1'b1;
                if (set_udf) begin
                    stack_udf <= 1'b1;
                end
            end else begin
                pc <= next_pc;
            end
            if (do_pop) begin
                stack_count <= stack_count - CNT_W'(1);
            end
            // A full stack still takes the jump; only the return address is lost
            if (do_push) begin
                if (stack_full) begin
                    stack_ovf <= 1'b1;
                end else begin
                    stack_count <= stack_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && commit && do_push && !stack_full) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule
